// File: rtl/svlog_adder_amba.sv
// AXI4-Lite slave with a 32-bit add/subtract unit and a 4-bit LED register.
// Registers: R0/R1 operands, R2 result, CTRL/STATUS, LED.
module svlog_adder_amba #(
  parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S00_AXI_ADDR_WIDTH = 5
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [(C_S00_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic [3:0]                          o_leds
);

  localparam int unsigned DW = C_S00_AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;

  logic [DW-1:0] r0_q, r0_d, r1_q, r1_d, r2_q, r2_d, led_q, led_d;
  logic [DW-1:0] sum_q, sum_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [2:0]    awidx_q, awidx_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic          done_q, done_d, pend_q, pend_d;
  logic          aw_buf_q, aw_buf_d, w_buf_q, w_buf_d;
  logic          awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic          arready_q, arready_d, rvalid_q, rvalid_d;
  logic          commit;
  logic [DW-1:0] rd_mux;

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(SW); i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    rd_mux = '0;
    case (s00_axi_araddr[4:2])
      3'd0:    rd_mux = r0_q;
      3'd1:    rd_mux = r1_q;
      3'd2:    rd_mux = r2_q;
      3'd3:    rd_mux = {done_q, {(DW-3){1'b0}}, ctrl_q};
      3'd4:    rd_mux = led_q;
      default: rd_mux = '0;
    endcase
  end

  // Commit only once per transaction: bvalid blocks re-commit until buffers free.
  assign commit = aw_buf_q && w_buf_q && !bvalid_q;

  always_comb begin
    r0_d      = r0_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    led_d     = led_q;
    sum_d     = sum_q;
    ctrl_d    = ctrl_q;
    done_d    = done_q;
    pend_d    = 1'b0;
    aw_buf_d  = aw_buf_q;
    awidx_d   = awidx_q;
    w_buf_d   = w_buf_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;

    awready_d = s00_axi_awvalid && !awready_q && !aw_buf_q && !bvalid_q;
    wready_d  = s00_axi_wvalid && !wready_q && !w_buf_q && !bvalid_q;
    arready_d = s00_axi_arvalid && !arready_q && !rvalid_q;

    if (awready_q && s00_axi_awvalid) begin
      aw_buf_d = 1'b1;
      awidx_d  = s00_axi_awaddr[4:2];
    end
    if (wready_q && s00_axi_wvalid) begin
      w_buf_d = 1'b1;
      wdata_d = s00_axi_wdata;
      wstrb_d = s00_axi_wstrb;
    end

    // Result lands one cycle after the START commit.
    if (pend_q) begin
      r2_d   = sum_q;
      done_d = 1'b1;
    end

    if (commit) begin
      bvalid_d = 1'b1;
      case (awidx_q)
        3'd0: r0_d  = merge_bytes(r0_q, wdata_q, wstrb_q);
        3'd1: r1_d  = merge_bytes(r1_q, wdata_q, wstrb_q);
        3'd3: begin
          done_d = 1'b0;
          if (wstrb_q[0]) begin
            ctrl_d = wdata_q[1:0];
            if (wdata_q[0]) begin
              pend_d = 1'b1;
              sum_d  = wdata_q[1] ? (r0_q + r1_q) : (r0_q - r1_q);
            end
          end
        end
        3'd4: led_d = merge_bytes(led_q, wdata_q, wstrb_q);
        default: ;
      endcase
    end

    if (bvalid_q && s00_axi_bready) begin
      bvalid_d = 1'b0;
      aw_buf_d = 1'b0;
      w_buf_d  = 1'b0;
    end

    if (arready_q && s00_axi_arvalid) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r0_q      <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      led_q     <= '0;
      sum_q     <= '0;
      ctrl_q    <= '0;
      done_q    <= 1'b0;
      pend_q    <= 1'b0;
      aw_buf_q  <= 1'b0;
      awidx_q   <= '0;
      w_buf_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r0_q      <= r0_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      led_q     <= led_d;
      sum_q     <= sum_d;
      ctrl_q    <= ctrl_d;
      done_q    <= done_d;
      pend_q    <= pend_d;
      aw_buf_q  <= aw_buf_d;
      awidx_q   <= awidx_d;
      w_buf_q   <= w_buf_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign o_leds          = led_q[3:0];

  logic unused_prot;
  assign unused_prot = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                         s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_svlog_adder_amba.sv
// Directed self-checking bench for svlog_adder_amba.
module tb_svlog_adder_amba;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [3:0]  leds;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  svlog_adder_amba dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .o_leds          (leds)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Independent AW/W launch delays; bready raised b_dly cycles after bvalid.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly, output int bcnt);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w, hs_b, done = 0;
    bcnt = 0;
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      awvalid = (cyc >= aw_dly) && !aw_done;
      wvalid  = (cyc >= w_dly) && !w_done;
      bready  = bvalid && (bcnt >= b_dly);
      hs_aw   = awvalid && awready;
      hs_w    = wvalid && wready;
      hs_b    = bvalid && bready;
      if (bvalid) bcnt++;
      if (hs_b) check_eq("bresp", {30'd0, bresp}, 32'd0);
      @(posedge clk); #1;
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done = 1;
      if (hs_b)  done = 1;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    if (!done) check_eq("write_timeout", 32'd0, 32'd1);
    check_eq("bvalid_dropped", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
    bit hs_ar, got = 0;
    data    = '0;
    araddr  = addr;
    arvalid = 1'b1;
    for (int cyc = 0; cyc < 50 && !got; cyc++) begin
      hs_ar = arvalid && arready;
      if (rvalid) begin
        data   = rdata;
        rready = 1'b1;
        got    = 1;
        check_eq("rresp", {30'd0, rresp}, 32'd0);
      end
      @(posedge clk); #1;
      if (hs_ar) arvalid = 1'b0;
      rready = 1'b0;
    end
    arvalid = 1'b0;
    if (!got) check_eq("read_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    int bc;
    axi_write(addr, data, 4'hF, 0, 0, 0, bc);
  endtask

  task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    axi_read(addr, v);
    check_eq(tag, v, exp);
  endtask

  task automatic run_op(input logic op_add);
    logic [31:0] v;
    bit seen = 0;
    wr(5'h0C, {30'd0, op_add, 1'b1});
    for (int i = 0; i < 20 && !seen; i++) begin
      axi_read(5'h0C, v);
      seen = v[31];
    end
    check_eq("done_seen", {31'd0, seen}, 32'd1);
    check_eq("ctrl_rb", v, {1'b1, 29'd0, op_add, 1'b1});
  endtask

  initial begin
    int bc;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_awready", {31'd0, awready}, 32'd0);
    check_eq("rst_wready", {31'd0, wready}, 32'd0);
    check_eq("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check_eq("rst_arready", {31'd0, arready}, 32'd0);
    check_eq("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_leds", {28'd0, leds}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    rd_check("rst_r0", 5'h00, 32'd0);
    rd_check("rst_r1", 5'h04, 32'd0);
    rd_check("rst_r2", 5'h08, 32'd0);
    rd_check("rst_ctrl", 5'h0C, 32'd0);
    rd_check("rst_led", 5'h10, 32'd0);

    wr(5'h00, 32'h2);
    wr(5'h04, 32'h1);
    rd_check("r0_rb", 5'h00, 32'h2);
    rd_check("r1_rb", 5'h04, 32'h1);

    run_op(1'b0);
    rd_check("sub_2_1", 5'h08, 32'h1);
    run_op(1'b1);
    rd_check("add_2_1", 5'h08, 32'h3);

    wr(5'h0C, 32'h2);
    rd_check("ctrl_nostart", 5'h0C, 32'h2);
    rd_check("r2_nostart", 5'h08, 32'h3);

    wr(5'h00, 32'h0);
    wr(5'h04, 32'h1);
    run_op(1'b0);
    rd_check("sub_wrap", 5'h08, 32'hFFFF_FFFF);

    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h04, 32'hFFFF_FFFF);
    run_op(1'b1);
    rd_check("add_wrap", 5'h08, 32'hFFFF_FFFE);

    wr(5'h10, 32'hF);
    rd_check("led_rb", 5'h10, 32'hF);
    check_eq("leds_out", {28'd0, leds}, 32'hF);

    wr(5'h00, 32'h0);
    axi_write(5'h00, 32'hAABB_CCDD, 4'b0010, 0, 0, 0, bc);
    rd_check("strb_r0", 5'h00, 32'h0000_CC00);

    axi_write(5'h04, 32'h1234_5678, 4'hF, 0, 4, 3, bc);
    check_eq("aw_first_bcnt", bc, 32'd4);
    rd_check("aw_first_rb", 5'h04, 32'h1234_5678);

    axi_write(5'h10, 32'h5, 4'hF, 4, 0, 3, bc);
    check_eq("w_first_bcnt", bc, 32'd4);
    check_eq("w_first_leds", {28'd0, leds}, 32'h5);

    wr(5'h08, 32'hDEAD_BEEF);
    rd_check("r2_ro", 5'h08, 32'hFFFF_FFFE);
    wr(5'h18, 32'h1234);
    rd_check("hole_rd", 5'h18, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
